// File: rtl/reg_file_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_arbiter: core/debug arbiter for one shared 8x16 register-file port  |
// | set. Core has priority; debug is forced in after STARVE_MAX blocked cycles. |
// | Optional macro RF_BYPASS_EN: same-transaction write-to-read forwarding.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module reg_file_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int DW         = 16,
    parameter int AW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_ra1,
    input  logic [AW-1:0] c_ra2,
    input  logic [AW-1:0] c_wa,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ready,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata_a,
    output logic [DW-1:0] c_rdata_b,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_ra1,
    input  logic [AW-1:0] d_ra2,
    input  logic [AW-1:0] d_wa,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata_a,
    output logic [DW-1:0] d_rdata_b,
    output logic          rf_en,
    output logic          rf_regen,
    output logic [AW-1:0] rf_readreg1,
    output logic [AW-1:0] rf_readreg2,
    output logic [AW-1:0] rf_writereg,
    output logic [DW-1:0] rf_data_result,
    input  logic [DW-1:0] rf_data_A,
    input  logic [DW-1:0] rf_data_B
);

    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_MAX);

    logic [7:0]    r_starve_cnt;
    logic          r_owner;          // owner of the slot issued last cycle: 1 = debug
    logic          w_force;
    logic          w_xfer;
    logic          w_we;
    logic [AW-1:0] w_ra1;
    logic [AW-1:0] w_ra2;
    logic [AW-1:0] w_wa;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_resp_a;
    logic [DW-1:0] w_resp_b;

    assign w_force = (r_starve_cnt == c_STARVE_MAX);
    assign d_ready = d_req && (w_force || !c_req);
    assign c_ready = c_req && !(w_force && d_req);
    assign w_xfer  = c_ready || d_ready;

    always_comb begin
        w_we    = c_we;
        w_ra1   = c_ra1;
        w_ra2   = c_ra2;
        w_wa    = c_wa;
        w_wdata = c_wdata;
        if (d_ready) begin
            w_we    = d_we;
            w_ra1   = d_ra1;
            w_ra2   = d_ra2;
            w_wa    = d_wa;
            w_wdata = d_wdata;
        end
    end

    // Issue stage: address/data hold their last values on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en          <= 1'b0;
            rf_regen       <= 1'b0;
            rf_readreg1    <= '0;
            rf_readreg2    <= '0;
            rf_writereg    <= '0;
            rf_data_result <= '0;
            r_owner        <= 1'b0;
        end else begin
            rf_en    <= w_xfer;
            rf_regen <= w_xfer && w_we;
            if (w_xfer) begin
                rf_readreg1    <= w_ra1;
                rf_readreg2    <= w_ra2;
                rf_writereg    <= w_wa;
                rf_data_result <= w_wdata;
                r_owner        <= d_ready;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (d_ready) begin
            r_starve_cnt <= '0;
        end else if (d_req && !w_force) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

`ifdef RF_BYPASS_EN
    logic r_byp_a;
    logic r_byp_b;

    // Compare captured at issue so the response edge only needs a mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_a <= 1'b0;
            r_byp_b <= 1'b0;
        end else if (w_xfer) begin
            r_byp_a <= w_we && (w_wa == w_ra1);
            r_byp_b <= w_we && (w_wa == w_ra2);
        end
    end

    assign w_resp_a = r_byp_a ? rf_data_result : rf_data_A;
    assign w_resp_b = r_byp_b ? rf_data_result : rf_data_B;
`else
    assign w_resp_a = rf_data_A;
    assign w_resp_b = rf_data_B;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            c_rdata_a <= '0;
            c_rdata_b <= '0;
            d_rdata_a <= '0;
            d_rdata_b <= '0;
        end else begin
            c_rvalid <= rf_en && !r_owner;
            d_rvalid <= rf_en && r_owner;
            if (rf_en && !r_owner) begin
                c_rdata_a <= w_resp_a;
                c_rdata_b <= w_resp_b;
            end
            if (rf_en && r_owner) begin
                d_rdata_a <= w_resp_a;
                d_rdata_b <= w_resp_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_file_arbiter: randomized and directed bench with a transaction-level |
// | reference model and an attached 8x16 register-file model.                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_reg_file_arbiter;

    localparam int STARVE = 4;
    localparam int DW     = 16;
    localparam int AW     = 3;
`ifdef RF_BYPASS_EN
    localparam logic [DW-1:0] c_RAW_EXP = 16'h00AA;
`else
    localparam logic [DW-1:0] c_RAW_EXP = 16'h0011;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_ra1, c_ra2, c_wa, d_ra1, d_ra2, d_wa;
    logic [DW-1:0] c_wdata, d_wdata;
    logic c_ready, c_rvalid, d_ready, d_rvalid;
    logic [DW-1:0] c_rdata_a, c_rdata_b, d_rdata_a, d_rdata_b;
    logic rf_en, rf_regen;
    logic [AW-1:0] rf_readreg1, rf_readreg2, rf_writereg;
    logic [DW-1:0] rf_data_result;
    logic [DW-1:0] rf_data_A = '0;
    logic [DW-1:0] rf_data_B = '0;

    reg_file_arbiter #(.STARVE_MAX(STARVE), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_ra1(c_ra1), .c_ra2(c_ra2), .c_wa(c_wa),
        .c_wdata(c_wdata), .c_ready(c_ready), .c_rvalid(c_rvalid),
        .c_rdata_a(c_rdata_a), .c_rdata_b(c_rdata_b),
        .d_req(d_req), .d_we(d_we), .d_ra1(d_ra1), .d_ra2(d_ra2), .d_wa(d_wa),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata_a(d_rdata_a), .d_rdata_b(d_rdata_b),
        .rf_en(rf_en), .rf_regen(rf_regen), .rf_readreg1(rf_readreg1),
        .rf_readreg2(rf_readreg2), .rf_writereg(rf_writereg),
        .rf_data_result(rf_data_result), .rf_data_A(rf_data_A), .rf_data_B(rf_data_B)
    );

    always #5 clk = ~clk;

    // Register file: at negedge reads old contents, then writes.
    logic [DW-1:0] rf_mem [8];
    always @(negedge clk) begin
        if (rf_en) begin
            rf_data_A <= rf_mem[rf_readreg1];
            rf_data_B <= rf_mem[rf_readreg2];
            if (rf_regen) rf_mem[rf_writereg] <= rf_data_result;
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [8];
    int n_vec = 0;
    int n_fail = 0;
    int m_cnt;
    bit obs_c_ready, obs_d_ready, e_c_ready, e_d_ready;
    bit e_rf_en, e_rf_regen, e_c_rvalid, e_d_rvalid, p_valid, p_dbg;
    logic [AW-1:0] e_ra1, e_ra2, e_wa;
    logic [DW-1:0] e_wd, e_c_a, e_c_b, e_d_a, e_d_b, p_a, p_b;

    task automatic m_reset();
        m_cnt = 0; p_valid = 0; p_dbg = 0; p_a = '0; p_b = '0;
        e_rf_en = 0; e_rf_regen = 0; e_ra1 = '0; e_ra2 = '0; e_wa = '0; e_wd = '0;
        e_c_rvalid = 0; e_d_rvalid = 0;
        e_c_a = '0; e_c_b = '0; e_d_a = '0; e_d_b = '0;
    endtask

    // One clock: decide the winner from the rules, update the model, advance.
    task automatic tick();
        bit cg, dg, we;
        logic [AW-1:0] ra1, ra2, wa;
        logic [DW-1:0] wd, a, b;
        #1;
        obs_c_ready = c_ready;
        obs_d_ready = d_ready;
        dg = d_req && (!c_req || m_cnt >= STARVE);
        cg = c_req && !dg;
        we  = dg ? d_we    : c_we;
        ra1 = dg ? d_ra1   : c_ra1;
        ra2 = dg ? d_ra2   : c_ra2;
        wa  = dg ? d_wa    : c_wa;
        wd  = dg ? d_wdata : c_wdata;
        a = ref_mem[ra1];
        b = ref_mem[ra2];
        if (cg || dg) begin
`ifdef RF_BYPASS_EN
            if (we && wa == ra1) a = wd;
            if (we && wa == ra2) b = wd;
`endif
            if (we) ref_mem[wa] = wd;
        end
        if (dg) m_cnt = 0;
        else if (d_req && m_cnt < STARVE) m_cnt++;
        e_c_ready = cg;
        e_d_ready = dg;
        @(posedge clk);
        #1;
        e_rf_en    = cg || dg;
        e_rf_regen = e_rf_en && we;
        if (e_rf_en) begin
            e_ra1 = ra1; e_ra2 = ra2; e_wa = wa; e_wd = wd;
        end
        e_c_rvalid = p_valid && !p_dbg;
        e_d_rvalid = p_valid && p_dbg;
        if (e_c_rvalid) begin e_c_a = p_a; e_c_b = p_b; end
        if (e_d_rvalid) begin e_d_a = p_a; e_d_b = p_b; end
        p_valid = e_rf_en; p_dbg = dg; p_a = a; p_b = b;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_ra1 = '0; c_ra2 = '0; c_wa = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_ra1 = '0; d_ra2 = '0; d_wa = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            c_req = 1'($urandom); d_req = 1'($urandom); c_we = 1'($urandom); d_we = 1'($urandom);
            c_ra1 = AW'($urandom); c_wa = AW'($urandom); c_wdata = DW'($urandom);
            d_ra2 = AW'($urandom); d_wdata = DW'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if ({rf_en, rf_regen, rf_readreg1, rf_readreg2, rf_writereg, rf_data_result} !== '0) begin
                n_fail++; $display("FAIL reset_rf: got %b/%b/%h/%h/%h/%h expected all 0",
                    rf_en, rf_regen, rf_readreg1, rf_readreg2, rf_writereg, rf_data_result);
            end
            n_vec++;
            if ({c_rvalid, d_rvalid, c_rdata_a, c_rdata_b, d_rdata_a, d_rdata_b} !== '0) begin
                n_fail++; $display("FAIL reset_resp: got %b/%b/%h/%h/%h/%h expected all 0",
                    c_rvalid, d_rvalid, c_rdata_a, c_rdata_b, d_rdata_a, d_rdata_b);
            end
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        m_reset();
        c_req = 1; c_ra1 = 3'd3;
        tick();
        c_req = 0;
        n_vec++;
        if (rf_en !== 1'b1 || rf_readreg1 !== 3'd3 || c_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL first_issue: got rf_en=%b ra1=%0d c_rvalid=%b expected 1/3/0",
                rf_en, rf_readreg1, c_rvalid);
        end
        tick();
        n_vec++;
        if (c_rvalid !== 1'b1 || rf_en !== 1'b0) begin
            n_fail++; $display("FAIL first_resp: got c_rvalid=%b rf_en=%b expected 1/0", c_rvalid, rf_en);
        end
        tick();
        n_vec++;
        if (c_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL first_resp_len: got c_rvalid=%b expected 0", c_rvalid);
        end
    endtask

    task automatic test_core_wr_rd();
        c_req = 1; c_we = 1; c_wa = 3'd5; c_wdata = 16'hBEEF;
        tick();
        c_we = 0; c_ra1 = 3'd5; c_ra2 = 3'd0;
        tick();
        c_req = 0;
        tick();
        n_vec++;
        if (c_rvalid !== 1'b1 || c_rdata_a !== 16'hBEEF || c_rdata_b !== 16'h0000) begin
            n_fail++; $display("FAIL core_wr_rd: got v=%b a=%h b=%h expected 1/beef/0000",
                c_rvalid, c_rdata_a, c_rdata_b);
        end
        tick();
        n_vec++;
        if (c_rvalid !== 1'b0 || c_rdata_a !== 16'hBEEF) begin
            n_fail++; $display("FAIL core_hold: got v=%b a=%h expected 0/beef", c_rvalid, c_rdata_a);
        end
    endtask

    task automatic test_contention();
        c_req = 1; d_req = 1; c_we = 0; d_we = 0;
        for (int i = 0; i < 15; i++) begin
            c_ra1 = AW'($urandom); c_ra2 = AW'($urandom);
            d_ra1 = AW'($urandom); d_ra2 = AW'($urandom);
            tick();
            n_vec++;
            if (obs_d_ready !== (i % 5 == 4) || obs_c_ready !== (i % 5 != 4)) begin
                n_fail++; $display("FAIL contention_grant cyc %0d: got c=%b d=%b expected d=%b",
                    i, obs_c_ready, obs_d_ready, (i % 5 == 4));
            end
            n_vec++;
            if ((c_rvalid && d_rvalid) !== 1'b0 || c_rvalid !== e_c_rvalid || d_rvalid !== e_d_rvalid) begin
                n_fail++; $display("FAIL contention_rvalid cyc %0d: got c=%b d=%b expected c=%b d=%b",
                    i, c_rvalid, d_rvalid, e_c_rvalid, e_d_rvalid);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_debug_alone();
        d_req = 1; d_we = 1; d_wa = 3'd7; d_wdata = 16'h1234;
        tick();
        d_we = 0; d_ra1 = 3'd1; d_ra2 = 3'd7;
        tick();
        d_req = 0;
        tick();
        n_vec++;
        if (d_rvalid !== 1'b1 || d_rdata_b !== 16'h1234 || c_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL debug_alone: got dv=%b db=%h cv=%b expected 1/1234/0",
                d_rvalid, d_rdata_b, c_rvalid);
        end
        tick();
    endtask

    task automatic test_raw();
        c_req = 1; c_we = 1; c_wa = 3'd2; c_wdata = 16'h0011;
        tick();
        c_wdata = 16'h00AA; c_ra1 = 3'd2; c_ra2 = 3'd2;
        tick();
        c_req = 0;
        tick();
        n_vec++;
        if (c_rdata_a !== c_RAW_EXP || c_rdata_b !== c_RAW_EXP) begin
            n_fail++; $display("FAIL same_txn_raw: got a=%h b=%h expected %h", c_rdata_a, c_rdata_b, c_RAW_EXP);
        end
        c_req = 1; c_we = 0;
        tick();
        c_req = 0;
        tick();
        n_vec++;
        if (c_rdata_a !== 16'h00AA) begin
            n_fail++; $display("FAIL raw_readback: got %h expected 00aa", c_rdata_a);
        end
    endtask

    task automatic test_back_to_back();
        c_req = 1; c_we = 1; c_wa = 3'd4; c_wdata = 16'h5A5A; c_ra1 = 3'd5; c_ra2 = 3'd7;
        tick();
        c_we = 0; c_ra1 = 3'd4; c_ra2 = 3'd5;
        tick();
        n_vec++;
        if (c_rvalid !== 1'b1 || rf_en !== 1'b1) begin
            n_fail++; $display("FAIL b2b_overlap: got rvalid=%b rf_en=%b expected 1/1", c_rvalid, rf_en);
        end
        c_req = 0;
        tick();
        n_vec++;
        if (c_rvalid !== 1'b1 || c_rdata_a !== 16'h5A5A || c_rdata_b !== 16'hBEEF) begin
            n_fail++; $display("FAIL b2b_raw: got v=%b a=%h b=%h expected 1/5a5a/beef",
                c_rvalid, c_rdata_a, c_rdata_b);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        c_req = 1; d_req = 1; c_ra1 = 3'd1;
        tick();
        tick();
        @(negedge clk); #1;
        rst_n = 0;
        idle_inputs();
        m_reset();
        #1;
        n_vec++;
        if (c_rvalid !== 1'b0 || rf_en !== 1'b0) begin
            n_fail++; $display("FAIL midreset_clear: got c_rvalid=%b rf_en=%b expected 0/0", c_rvalid, rf_en);
        end
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1;
        tick();
        n_vec++;
        if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_resp: got c=%b d=%b expected 0/0", c_rvalid, d_rvalid);
        end
        c_req = 1; d_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (obs_d_ready !== (i == 4)) begin
                n_fail++; $display("FAIL midreset_starve cyc %0d: got d_ready=%b expected %b",
                    i, obs_d_ready, (i == 4));
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!c_req || e_c_ready) begin
                c_req = ($urandom_range(3) != 0); c_we = 1'($urandom);
                c_ra1 = AW'($urandom); c_ra2 = AW'($urandom); c_wa = AW'($urandom); c_wdata = DW'($urandom);
            end else if ($urandom_range(15) == 0) c_req = 0;
            if (!d_req || e_d_ready) begin
                d_req = 1'($urandom); d_we = 1'($urandom);
                d_ra1 = AW'($urandom); d_ra2 = AW'($urandom); d_wa = AW'($urandom); d_wdata = DW'($urandom);
            end else if ($urandom_range(15) == 0) d_req = 0;
            tick();
            n_vec++;
            if (obs_c_ready !== e_c_ready || obs_d_ready !== e_d_ready) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d: got c=%b d=%b expected c=%b d=%b",
                    i, obs_c_ready, obs_d_ready, e_c_ready, e_d_ready);
            end
            n_vec++;
            if ({rf_en, rf_regen, rf_readreg1, rf_readreg2, rf_writereg, rf_data_result} !==
                {e_rf_en, e_rf_regen, e_ra1, e_ra2, e_wa, e_wd}) begin
                n_fail++; $display("FAIL rnd_rf cyc %0d: got %b/%b/%h/%h/%h/%h expected %b/%b/%h/%h/%h/%h", i,
                    rf_en, rf_regen, rf_readreg1, rf_readreg2, rf_writereg, rf_data_result,
                    e_rf_en, e_rf_regen, e_ra1, e_ra2, e_wa, e_wd);
            end
            n_vec++;
            if ({c_rvalid, c_rdata_a, c_rdata_b} !== {e_c_rvalid, e_c_a, e_c_b}) begin
                n_fail++; $display("FAIL rnd_core_resp cyc %0d: got %b/%h/%h expected %b/%h/%h",
                    i, c_rvalid, c_rdata_a, c_rdata_b, e_c_rvalid, e_c_a, e_c_b);
            end
            n_vec++;
            if ({d_rvalid, d_rdata_a, d_rdata_b} !== {e_d_rvalid, e_d_a, e_d_b}) begin
                n_fail++; $display("FAIL rnd_dbg_resp cyc %0d: got %b/%h/%h expected %b/%h/%h",
                    i, d_rvalid, d_rdata_a, d_rdata_b, e_d_rvalid, e_d_a, e_d_b);
            end
        end
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            rf_mem[k]  = '0;
            ref_mem[k] = '0;
        end
        m_reset();
        e_c_ready = 0;
        e_d_ready = 0;
        #2 rst_n = 0;
        test_reset();
        test_core_wr_rd();
        test_contention();
        test_debug_alone();
        test_raw();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
